edge_frame_writer: RTL and testbench
====================================

// Module: edge_frame_writer
// PURPOSE
//  Downstream consumer of the edge-filter pixel stream. It discards the filter's pipeline-fill pixels,
//  then captures one WIDTH x HEIGHT frame of edge magnitudes. Captured pixels are buffered in a small
//  FIFO and written to frame-buffer memory over a req/ack handshake. It sits between the edge filter
//  and the VGA frame buffer, sharing the filter's Clk/en pixel strobe.
// PARAMETERS
//  WIDTH       100   pixels per line (must match filter Width)
//  HEIGHT      100   lines per frame
//  SKIP        302   en-strobed pixels discarded after start (filter fill latency, BUFF+2)
//  ADDR_W      14    memory address width; WIDTH*HEIGHT <= 2**ADDR_W
//  FIFO_DEPTH  4     write-buffer entries, power of two, >= 2
//  THRESH      32    binarise threshold (used only with EDGE_WR_THRESH_EN)
// PORTS
//  Clk       in   1       system clock, all logic on posedge
//  nReset    in   1       asynchronous active-low reset
//  en        in   1       pixel strobe; PixelIn valid when high
//  PixelIn   in   8       edge magnitude from filter PixelOut
//  start     in   1       begin capture of one frame (honoured in IDLE only)
//  busy      out  1       high in any state other than IDLE
//  done      out  1       one-cycle pulse when the last pixel is written to memory
//  overflow  out  1       sticky: a pixel was dropped because the FIFO was full
//  mem_req   out  1       write request, held until acked
//  mem_addr  out  ADDR_W  write address, linear y*WIDTH+x
//  mem_data  out  8       write data
//  mem_ack   in   1       memory accepted current request this cycle
// BEHAVIOUR
//  Reset (async, nReset=0): state IDLE; busy=0, done=0, overflow=0, mem_req=0, mem_addr=0, mem_data=0;
//   FIFO emptied; counters=0. Reset mid-frame abandons the frame; no further mem_req is issued.
//  FSM: IDLE -start-> SKIP (SKIP=0: straight to CAPTURE); SKIP -SKIP-th en-> CAPTURE;
//   CAPTURE -(WIDTH*HEIGHT)-th en-> DRAIN; DRAIN -FIFO empty & !mem_req-> DONE; DONE -> IDLE (1 cycle).
//  start outside IDLE is ignored. Accepting start clears overflow and the skip/x/y/addr counters.
//  SKIP: each en decrements the skip count. Pixels are discarded, with no memory traffic.
//  CAPTURE: each en pushes {addr, pixel} to the FIFO.
//   x wraps WIDTH-1 -> 0 and increments y; addr increments by 1 per en (no multiplier).
//   en in the cycle that leaves SKIP is discarded; the first capture is the next en.
//  Push when full: allowed only if a pop occurs in the same cycle; otherwise the pixel is dropped and
//   overflow<=1. addr/x/y still advance on a drop, so frame geometry is preserved.
//  Handshake: mem_req=1 whenever the FIFO is non-empty; mem_addr/mem_data = FIFO head, stable while
//   mem_req=1 and mem_ack=0. mem_req=1 & mem_ack=1 pops the head. The next entry is presented the
//   following cycle; mem_req may stay high back-to-back (1 write/cycle max).
//   mem_ack while mem_req=0 is ignored.
//  Latency: a pixel pushed into an empty FIFO at cycle N appears on mem_req/mem_data at cycle N+1.
//  done asserts in the DONE cycle only. busy drops in the same cycle the FSM returns to IDLE.
//  en in IDLE/DRAIN/DONE is ignored. Simultaneous push and pop with 1 entry keeps mem_req high.
// CONFIGURATION
//  EDGE_WR_THRESH_EN defined: the stored pixel is (PixelIn >= THRESH) ? 8'hFF : 8'h00, giving a binary
//   edge map. Threshold test is unsigned and applied at push.
//  Not defined: PixelIn is stored unmodified; THRESH is unused.
// TESTING
//  1 Reset: nReset=0 mid-CAPTURE with FIFO holding 3 -> outputs 0, busy=0, no mem_req after release.
//  2 WIDTH=4,HEIGHT=2,SKIP=3, mem_ack tied 1, en every cycle, PixelIn=0..10 -> writes addr 0..7,
//    data 3..10. done pulses once, 1 cycle after last write.
//  3 Backpressure: mem_ack=0 for 10 cycles with en continuous, FIFO_DEPTH=4 -> 4 entries held,
//    addr/data stable, overflow=1. After release, addresses skip the dropped positions.
//  4 Full+pop same cycle: FIFO full, mem_ack=1 and en=1 together -> pixel accepted, overflow stays 0.
//  5 start pulsed while busy -> ignored, no restart; start in IDLE after done -> overflow cleared,
//    new frame from addr 0.
//  6 EDGE_WR_THRESH_EN, THRESH=32: PixelIn 31,32,200 -> mem_data 00,FF,FF; undefined -> 31,32,200.

Source files
------------

// File: rtl/edge_frame_writer_if.sv
// Pixel-stream input and frame-buffer write bus of edge_frame_writer.
// Latency: none, signal bundle only.
// Backpressure: mem_req held with stable mem_addr/mem_data until mem_ack.
interface edge_frame_writer_if #(
    parameter int ADDR_W = 14
);
    logic              en;
    logic [7:0]        PixelIn;
    logic              start;
    logic              busy;
    logic              done;
    logic              overflow;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_data;
    logic              mem_ack;

    // Writer side: consumes the pixel stream, masters the memory write bus.
    modport master (
        input  en,
        input  PixelIn,
        input  start,
        input  mem_ack,
        output busy,
        output done,
        output overflow,
        output mem_req,
        output mem_addr,
        output mem_data
    );

    // Environment side: filter strobe, control and the frame-buffer memory.
    modport slave (
        output en,
        output PixelIn,
        output start,
        output mem_ack,
        input  busy,
        input  done,
        input  overflow,
        input  mem_req,
        input  mem_addr,
        input  mem_data
    );
endinterface

// File: rtl/edge_frame_writer.sv
// Skips filter fill pixels, captures one WIDTH x HEIGHT frame, writes it to memory via a FIFO.
// Latency: a pixel pushed into an empty FIFO is presented on mem_req/mem_data one cycle later.
// Backpressure: mem_ack stalls the FIFO; a pixel arriving when full with no pop is dropped (sticky overflow).
// Optional feature macro: EDGE_WR_THRESH_EN (store PixelIn >= THRESH ? 8'hFF : 8'h00).

// Generic synchronous FIFO: push accepted when not full, or when full and popping this cycle.
// Latency: a push is visible at the head one cycle later.
// Backpressure: push_rdy low when full and no pop; pop ignored when empty.
module edge_frame_writer_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         Clk,
    input  logic         nReset,
    input  logic         push_vld,
    input  logic [W-1:0] push_dat,
    output logic         push_rdy,
    input  logic         pop,
    output logic         head_vld,
    output logic [W-1:0] head_dat
);
    localparam int AW = (DEPTH < 2) ? 1 : $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          full;
    logic          push_ok;
    logic          pop_ok;

    assign full     = (count == (AW+1)'(DEPTH));
    assign head_vld = (count != '0);
    assign pop_ok   = pop && head_vld;
    assign push_rdy = !full || pop_ok;
    assign push_ok  = push_vld && push_rdy;
    assign head_dat = mem[rd_ptr];

    // Storage write; contents need no reset because head_vld qualifies every read.
    always_ff @(posedge Clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

module edge_frame_writer #(
    parameter int WIDTH      = 100,
    parameter int HEIGHT     = 100,
    parameter int SKIP       = 302,
    parameter int ADDR_W     = 14,
    parameter int FIFO_DEPTH = 4,
    parameter int THRESH     = 32
) (
    input  logic                Clk,
    input  logic                nReset,
    edge_frame_writer_if.master bus
);
    localparam int X_W    = (WIDTH  < 2) ? 1 : $clog2(WIDTH);
    localparam int Y_W    = (HEIGHT < 2) ? 1 : $clog2(HEIGHT);
    localparam int SKIP_W = (SKIP   < 2) ? 1 : $clog2(SKIP + 1);
    localparam logic [X_W-1:0]    X_LAST    = X_W'(WIDTH - 1);
    localparam logic [Y_W-1:0]    Y_LAST    = Y_W'(HEIGHT - 1);
    localparam logic [SKIP_W-1:0] SKIP_LOAD = SKIP_W'(SKIP);

    // Parameter sanity, caught at elaboration rather than as silent address aliasing.
    if (WIDTH * HEIGHT > (1 << ADDR_W)) begin : g_bad_geometry
        $error("WIDTH*HEIGHT does not fit in ADDR_W address bits");
    end
    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of two and at least 2");
    end
    if ((THRESH < 0) || (THRESH > 255)) begin : g_bad_thresh
        $error("THRESH must fit in 8 bits");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_SKIP,
        S_CAPTURE,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t            state;
    logic              busy_r;
    logic              done_r;
    logic              overflow_r;
    logic [SKIP_W-1:0] skip_cnt;
    logic [X_W-1:0]    x_cnt;
    logic [Y_W-1:0]    y_cnt;
    logic [ADDR_W-1:0] addr_cnt;

    logic              capture_en;
    logic              last_pix;
    logic [7:0]        pix_st;
    logic              push_rdy;
    logic              head_vld;
    logic [ADDR_W+7:0] head_dat;
    logic              pop;

    assign capture_en = (state == S_CAPTURE) && bus.en;
    assign last_pix   = (x_cnt == X_LAST) && (y_cnt == Y_LAST);

`ifdef EDGE_WR_THRESH_EN
    localparam logic [7:0] THRESH_B = 8'(THRESH);
    // Binary edge map: unsigned compare applied on the way into the FIFO.
    assign pix_st = (bus.PixelIn >= THRESH_B) ? 8'hFF : 8'h00;
`else
    assign pix_st = bus.PixelIn;
`endif

    // A pop is a granted request; ack without an outstanding request does nothing.
    assign pop = head_vld && bus.mem_ack;

    edge_frame_writer_fifo #(
        .W     (ADDR_W + 8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .Clk      (Clk),
        .nReset   (nReset),
        .push_vld (capture_en),
        .push_dat ({addr_cnt, pix_st}),
        .push_rdy (push_rdy),
        .pop      (pop),
        .head_vld (head_vld),
        .head_dat (head_dat)
    );

    // Head is gated so the bus reads all-zero whenever no request is outstanding.
    assign bus.mem_req  = head_vld;
    assign bus.mem_addr = head_vld ? head_dat[ADDR_W+7:8] : '0;
    assign bus.mem_data = head_vld ? head_dat[7:0]        : 8'h00;
    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.overflow = overflow_r;

    // Frame FSM with its counters and registered status outputs.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            state      <= S_IDLE;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            overflow_r <= 1'b0;
            skip_cnt   <= '0;
            x_cnt      <= '0;
            y_cnt      <= '0;
            addr_cnt   <= '0;
        end else begin
            done_r <= 1'b0;
            // Dropped pixel: the FIFO was full and nothing left it this cycle.
            if (capture_en && !push_rdy) begin
                overflow_r <= 1'b1;
            end
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        busy_r     <= 1'b1;
                        overflow_r <= 1'b0;
                        skip_cnt   <= SKIP_LOAD;
                        x_cnt      <= '0;
                        y_cnt      <= '0;
                        addr_cnt   <= '0;
                        state      <= (SKIP == 0) ? S_CAPTURE : S_SKIP;
                    end
                end
                S_SKIP: begin
                    // The strobe that exhausts the count is itself discarded.
                    if (bus.en) begin
                        skip_cnt <= skip_cnt - SKIP_W'(1);
                        if (skip_cnt == SKIP_W'(1)) begin
                            state <= S_CAPTURE;
                        end
                    end
                end
                S_CAPTURE: begin
                    // Geometry advances on every strobe, even when the pixel is dropped.
                    if (bus.en) begin
                        addr_cnt <= addr_cnt + ADDR_W'(1);
                        if (x_cnt == X_LAST) begin
                            x_cnt <= '0;
                            y_cnt <= y_cnt + Y_W'(1);
                        end else begin
                            x_cnt <= x_cnt + X_W'(1);
                        end
                        if (last_pix) begin
                            state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (!head_vld) begin
                        done_r <= 1'b1;
                        state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    busy_r <= 1'b0;
                    state  <= S_IDLE;
                end
                default: begin
                    busy_r <= 1'b0;
                    state  <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_edge_frame_writer.sv
// Directed bench for edge_frame_writer (WIDTH=4, HEIGHT=2, SKIP=3, FIFO_DEPTH=4).
// Cycle tables cover streaming, backpressure with drops, full+pop, start handling and output data mapping.
// Hand sequence covers asynchronous reset in the middle of a capture.
module tb_edge_frame_writer;
    localparam int ADDR_W = 14;

    logic Clk;
    logic nReset;
    int   n_checks;
    int   n_errors;

    edge_frame_writer_if #(.ADDR_W(ADDR_W)) bus ();

    edge_frame_writer #(
        .WIDTH      (4),
        .HEIGHT     (2),
        .SKIP       (3),
        .ADDR_W     (ADDR_W),
        .FIFO_DEPTH (4),
        .THRESH     (32)
    ) dut (
        .Clk    (Clk),
        .nReset (nReset),
        .bus    (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic              start;
        logic              en;
        logic              ack;
        logic [7:0]        pix;
        logic              busy;
        logic              done;
        logic              ovf;
        logic              req;
        logic [ADDR_W-1:0] addr;
        logic [7:0]        data;
    } vec_t;

    vec_t vecs[64];
    int   nvec;

    // Stored value for a raw pixel under the current build.
    function automatic logic [7:0] fx(input logic [7:0] p);
`ifdef EDGE_WR_THRESH_EN
        return (p >= 8'd32) ? 8'hFF : 8'h00;
`else
        return p;
`endif
    endfunction

    task automatic add(input logic st, input logic en, input logic ack, input int pix,
                       input logic busy, input logic done, input logic ovf, input logic req,
                       input int addr, input int data);
        vecs[nvec].start = st;
        vecs[nvec].en    = en;
        vecs[nvec].ack   = ack;
        vecs[nvec].pix   = 8'(pix);
        vecs[nvec].busy  = busy;
        vecs[nvec].done  = done;
        vecs[nvec].ovf   = ovf;
        vecs[nvec].req   = req;
        vecs[nvec].addr  = ADDR_W'(addr);
        vecs[nvec].data  = fx(8'(data));
        nvec++;
    endtask

    task automatic check(input string nm, input logic busy, input logic done, input logic ovf,
                         input logic req, input logic [ADDR_W-1:0] addr, input logic [7:0] data);
        n_checks++;
        if ({bus.busy, bus.done, bus.overflow, bus.mem_req, bus.mem_addr, bus.mem_data} !==
            {busy, done, ovf, req, addr, data}) begin
            n_errors++;
            $display("FAIL %s: got busy=%b done=%b ovf=%b req=%b addr=%0d data=%h, want busy=%b done=%b ovf=%b req=%b addr=%0d data=%h",
                     nm, bus.busy, bus.done, bus.overflow, bus.mem_req, bus.mem_addr, bus.mem_data,
                     busy, done, ovf, req, addr, data);
        end
    endtask

    task automatic drive(input logic st, input logic en, input logic ack, input logic [7:0] pix);
        bus.start   = st;
        bus.en      = en;
        bus.mem_ack = ack;
        bus.PixelIn = pix;
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        nvec     = 0;

        // Frame A: mem_ack held high, en every cycle, pixels 0..10 (+ ignored pixels in DRAIN).
        add(1,0,1,  0,  1,0,0,0, 0, 0);
        add(0,1,1,  0,  1,0,0,0, 0, 0);
        add(0,1,1,  1,  1,0,0,0, 0, 0);
        add(0,1,1,  2,  1,0,0,0, 0, 0);
        add(0,1,1,  3,  1,0,0,1, 0, 3);
        add(0,1,1,  4,  1,0,0,1, 1, 4);
        add(0,1,1,  5,  1,0,0,1, 2, 5);
        add(0,1,1,  6,  1,0,0,1, 3, 6);
        add(0,1,1,  7,  1,0,0,1, 4, 7);
        add(0,1,1,  8,  1,0,0,1, 5, 8);
        add(0,1,1,  9,  1,0,0,1, 6, 9);
        add(0,1,1, 10,  1,0,0,1, 7,10);
        add(0,1,1, 11,  1,0,0,0, 0, 0);
        add(0,1,1, 12,  1,1,0,0, 0, 0);
        add(0,0,1,  0,  0,0,0,0, 0, 0);
        // Frame B: ack low for 10 cycles, FIFO fills, addr 4/5 dropped, then drains 1,2,3,6,7.
        add(1,0,0,  0,  1,0,0,0, 0, 0);
        add(0,1,0, 20,  1,0,0,0, 0, 0);
        add(0,1,0, 21,  1,0,0,0, 0, 0);
        add(0,1,0, 22,  1,0,0,0, 0, 0);
        add(0,1,0, 30,  1,0,0,1, 0,30);
        add(0,1,0, 31,  1,0,0,1, 0,30);
        add(0,1,0, 32,  1,0,0,1, 0,30);
        add(0,1,0,200,  1,0,0,1, 0,30);
        add(0,1,0, 34,  1,0,1,1, 0,30);
        add(0,1,0, 35,  1,0,1,1, 0,30);
        add(0,1,1, 36,  1,0,1,1, 1,31);
        add(0,1,1, 37,  1,0,1,1, 2,32);
        add(0,0,1,  0,  1,0,1,1, 3,200);
        add(0,0,1,  0,  1,0,1,1, 6,36);
        add(0,0,1,  0,  1,0,1,1, 7,37);
        add(0,0,1,  0,  1,0,1,0, 0, 0);
        add(0,0,1,  0,  1,1,1,0, 0, 0);
        add(0,0,1,  0,  0,0,1,0, 0, 0);
        // Frame C: start clears overflow; start while busy ignored; full + pop + push same cycle.
        add(1,0,0,  0,  1,0,0,0, 0, 0);
        add(0,1,0,  0,  1,0,0,0, 0, 0);
        add(1,1,0,  0,  1,0,0,0, 0, 0);
        add(0,1,0,  0,  1,0,0,0, 0, 0);
        add(0,1,0, 50,  1,0,0,1, 0,50);
        add(0,1,0, 51,  1,0,0,1, 0,50);
        add(0,1,0, 52,  1,0,0,1, 0,50);
        add(0,1,0, 53,  1,0,0,1, 0,50);
        add(0,1,1, 54,  1,0,0,1, 1,51);
        add(0,1,1, 55,  1,0,0,1, 2,52);
        add(0,1,1, 56,  1,0,0,1, 3,53);
        add(0,1,1, 57,  1,0,0,1, 4,54);
        add(1,0,1,  0,  1,0,0,1, 5,55);
        add(0,0,1,  0,  1,0,0,1, 6,56);
        add(0,0,1,  0,  1,0,0,1, 7,57);
        add(0,0,1,  0,  1,0,0,0, 0, 0);
        add(0,0,1,  0,  1,1,0,0, 0, 0);
        add(0,0,1,  0,  0,0,0,0, 0, 0);

        // Power-on reset.
        nReset = 1'b0;
        drive(0, 0, 0, 8'h00);
        repeat (2) @(posedge Clk);
        #1;
        check("reset state", 0,0,0,0, '0, 8'h00);
        #3 nReset = 1'b1;
        tick();
        check("idle after reset", 0,0,0,0, '0, 8'h00);

        for (int i = 0; i < nvec; i++) begin
            drive(vecs[i].start, vecs[i].en, vecs[i].ack, vecs[i].pix);
            tick();
            check($sformatf("table vec %0d", i), vecs[i].busy, vecs[i].done, vecs[i].ovf,
                  vecs[i].req, vecs[i].addr, vecs[i].data);
        end

        // Reset mid-capture with three entries held in the FIFO.
        drive(1, 0, 0, 8'h00);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 0, 8'h00);
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 0, 8'(90 + i));
            tick();
        end
        check("pre-reset three held", 1,0,0,1, '0, fx(8'd90));
        #2 nReset = 1'b0;
        #1;
        check("async reset outputs", 0,0,0,0, '0, 8'h00);
        tick();
        check("held in reset", 0,0,0,0, '0, 8'h00);
        #3 nReset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            drive(0, 1, i[0], 8'(100 + i));
            tick();
            check($sformatf("post-reset quiet %0d", i), 0,0,0,0, '0, 8'h00);
        end

        drive(0, 0, 0, 8'h00);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
